fifo_ptr_ctrl: RTL

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

---
 rtl/fifo_ptr_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Purpose: FIFO pointer/handshake controller; grants one write or read per strobe, tracks shadow occupancy.
// Latency: request sampled in IDLE -> registered ack/strobe next cycle; one transfer per 2 cycles max.
// Backpressure: WR_REQ/RD_REQ held until ack; refused at FIFOFULL/FIFOEMPTY or OCC limits 8/0.
module fifo_ptr_ctrl (
    input  logic       CLK,
    input  logic       RESET_,
    input  logic       FLUSH,
    input  logic       WR_REQ,
    input  logic       RD_REQ,
    input  logic       FIFOFULL,
    input  logic       FIFOEMPTY,
    output logic       WR_ACK,
    output logic       RD_ACK,
    output logic       INCFIFO,
    output logic       DECFIFO,
    output logic       RST_FIFO_,
    output logic [2:0] WPTR,
    output logic [2:0] RPTR,
    output logic [3:0] OCC
);

    typedef enum logic [1:0] {IDLE, WSTB, RSTB, FLSH} state_t;

    state_t     state, next_state;
    logic [3:0] wptr4, rptr4, occ_q;
    logic [3:0] wptr4_nxt, rptr4_nxt, occ_nxt;
    logic       wr_pri, wr_pri_nxt;
    logic       wr_ok, rd_ok;
    logic       wr_ack_nxt, rd_ack_nxt, rst_fifo_nxt;

    // State, pointers and all outputs are flops; outputs load from next-state decode.
    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            state     <= FLSH;
            wptr4     <= 4'd0;
            rptr4     <= 4'd0;
            occ_q     <= 4'd0;
            wr_pri    <= 1'b1;
            WR_ACK    <= 1'b0;
            RD_ACK    <= 1'b0;
            INCFIFO   <= 1'b0;
            DECFIFO   <= 1'b0;
            RST_FIFO_ <= 1'b0;
        end else begin
            state     <= next_state;
            wptr4     <= wptr4_nxt;
            rptr4     <= rptr4_nxt;
            occ_q     <= occ_nxt;
            wr_pri    <= wr_pri_nxt;
            WR_ACK    <= wr_ack_nxt;
            RD_ACK    <= rd_ack_nxt;
            INCFIFO   <= wr_ack_nxt;
            DECFIFO   <= rd_ack_nxt;
            RST_FIFO_ <= rst_fifo_nxt;
        end
    end

    always_comb begin
        wr_ok      = WR_REQ && !FIFOFULL && (occ_q < 4'd8);
        rd_ok      = RD_REQ && !FIFOEMPTY && (occ_q != 4'd0);
        next_state = state;
        case (state)
            IDLE: begin
                if (wr_ok && (!rd_ok || wr_pri))
                    next_state = WSTB;
                else if (rd_ok)
                    next_state = RSTB;
            end
            WSTB, RSTB, FLSH: next_state = IDLE;
            default:          next_state = FLSH;
        endcase
        if (FLUSH)
            next_state = FLSH;
    end

    // A strobe interrupted by flush still completes, but its increment is lost to the clear.
    always_comb begin
        wptr4_nxt    = wptr4;
        rptr4_nxt    = rptr4;
        occ_nxt      = occ_q;
        wr_pri_nxt   = wr_pri;
        wr_ack_nxt   = (next_state == WSTB);
        rd_ack_nxt   = (next_state == RSTB);
        rst_fifo_nxt = (next_state != FLSH);
        if (next_state == FLSH) begin
            wptr4_nxt  = 4'd0;
            rptr4_nxt  = 4'd0;
            occ_nxt    = 4'd0;
            wr_pri_nxt = 1'b1;
        end else begin
            if (state == WSTB) begin
                wptr4_nxt = wptr4 + 4'd1;
                occ_nxt   = occ_q + 4'd1;
            end
            if (state == RSTB) begin
                rptr4_nxt = rptr4 + 4'd1;
                occ_nxt   = occ_q - 4'd1;
            end
            if (next_state == WSTB)
                wr_pri_nxt = 1'b0;
            if (next_state == RSTB)
                wr_pri_nxt = 1'b1;
        end
    end

    assign WPTR = wptr4[2:0];
    assign RPTR = rptr4[2:0];
    assign OCC  = occ_q;

endmodule
